i2s_top_rx: RTL and testbench

I2S_TOP_RX -- requirements
Module: i2s_top_rx

---
 rtl/i2s_top_rx_if.sv | 30 +++
 rtl/i2s_top_rx.sv | 129 ++++++++++++
 tb/tb_i2s_top_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_top_rx_if.sv
// i2s_top_rx_if -- signal bundle for the I2S master receiver.
//
// Groups the serial bus and the parallel word output of i2s_top_rx so a
// consumer or a bench can carry them as one object.
//   master : the receiver side (drives sclk/wsel and the word outputs,
//            consumes sdat)
//   slave  : the transmitter/consumer side (drives sdat, observes the rest)
//
// Handshake: there is none. write is a one-cycle strobe; data and lr_chnl
// are valid only while write=1 and the consumer must capture them then.
interface i2s_top_rx_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  sdat;
    logic                  sclk;
    logic                  wsel;
    logic [WORD_WIDTH-1:0] data;
    logic                  lr_chnl;
    logic                  write;

    modport master (
        input  sdat,
        output sclk, wsel, data, lr_chnl, write
    );

    modport slave (
        output sdat,
        input  sclk, wsel, data, lr_chnl, write
    );
endinterface

// File: rtl/i2s_top_rx.sv
// i2s_top_rx -- I2S bus master receiver.
//
// Generates the I2S bit clock and word select, samples one serial bit per
// system clock, and presents each completed channel word on a parallel
// output with a one-cycle write strobe.
//
// Ports:
//   clk_i       in   system clock, all state changes on its rising edge
//   rst_i       in   synchronous active-low reset
//   sdat_i      in   I2S serial data (transmitter changes it on sclk_o fall)
//   sclk_o      out  I2S bit clock: clk_i while out of reset, 0 in reset
//   wsel_o      out  I2S word select (0 = left, 1 = right), registered
//   data_o      out  last completed word, registered
//   lr_chnl_o   out  channel of data_o (0 = left, 1 = right), registered
//   write_o     out  one-cycle strobe marking data_o/lr_chnl_o valid
//   frame_cnt_o out  [15:0] count of right-channel writes, wraps at FFFF
//                    (present only when I2S_RX_FRAME_CNT_EN is defined)
//
// Optional feature macro: I2S_RX_FRAME_CNT_EN
//
// Timing after reset release (edge 1 = first non-reset rising edge):
//   edge 1                 delay-slot sample, discarded
//   edges 2..W+1           left word, MSB first
//   edge  W+2              data_o/lr_chnl_o loaded, write_o=1
//   every W edges after    next word, channels alternating
module i2s_top_rx #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sdat_i,
    output logic                  sclk_o,
    output logic                  wsel_o,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  lr_chnl_o,
    output logic                  write_o
`ifdef I2S_RX_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt_o
`endif
);

    localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_WIDTH - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(1);

    logic [CW-1:0]         cnt_q,     cnt_d;
    logic                  wsel_q,    wsel_d;
    logic [WORD_WIDTH-1:0] shift_q,   shift_d;
    logic [WORD_WIDTH-1:0] data_q,    data_d;
    logic                  lr_chnl_q, lr_chnl_d;
    logic                  write_q,   write_d;
    logic                  armed_q,   armed_d;
    logic                  load;

    // The bit clock is the system clock gated by reset; data is sampled on
    // the same edge the receiver flops see.
    assign sclk_o = rst_i ? clk_i : 1'b0;

    always_comb begin
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        wsel_d    = wsel_q ^ (cnt_q == CNT_LAST);
        shift_d   = {shift_q[WORD_WIDTH-2:0], sdat_i};

        // The first cnt==1 edge after reset would only deliver the
        // delay-slot bit; armed_q suppresses that one load.
        armed_d   = armed_q | (cnt_q == CNT_LOAD);
        load      = armed_q && (cnt_q == CNT_LOAD);

        data_d    = data_q;
        lr_chnl_d = lr_chnl_q;
        write_d   = 1'b0;
        if (load) begin
            // By now wsel has already moved on to the other channel, so the
            // finished word belongs to the inverse of the current wsel.
            data_d    = shift_q;
            lr_chnl_d = ~wsel_q;
            write_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            wsel_q    <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            lr_chnl_q <= 1'b0;
            write_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wsel_q    <= wsel_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            lr_chnl_q <= lr_chnl_d;
            write_q   <= write_d;
            armed_q   <= armed_d;
        end
    end

    assign wsel_o    = wsel_q;
    assign data_o    = data_q;
    assign lr_chnl_o = lr_chnl_q;
    assign write_o   = write_q;

`ifdef I2S_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // A stereo frame is complete when its right word is written.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (load && !wsel_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_top_rx.sv
// tb_i2s_top_rx -- self-checking bench for i2s_top_rx (WORD_WIDTH=16).
//
// The reference model records every bit driven after reset release,
// cuts the stream into words by the I2S framing rules (one delay bit,
// then W bits per word, channels alternating from left) and queues the
// expected words; the DUT write strobes pop that queue.
module tb_i2s_top_rx;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk = ~clk;

    i2s_top_rx_if #(.WORD_WIDTH(W)) bus ();

`ifdef I2S_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    i2s_top_rx #(.WORD_WIDTH(W)) dut (
`ifdef I2S_RX_FRAME_CNT_EN
        .frame_cnt_o (frame_cnt),
`endif
        .clk_i       (clk),
        .rst_i       (rst_i),
        .sdat_i      (bus.sdat),
        .sclk_o      (bus.sclk),
        .wsel_o      (bus.wsel),
        .data_o      (bus.data),
        .lr_chnl_o   (bus.lr_chnl),
        .write_o     (bus.write)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           edge_n;       // rising edges since reset release
    bit           hist[$];      // hist[i] = bit sampled on edge i+1
    logic [W-1:0] exp_q[$];     // completed words awaiting their write
    bit           exp_ch_q[$];
    logic [W-1:0] cur_data;
    bit           cur_lr;
    int           frames;

    // Log of observed writes, for the fixed-pattern spot checks
    int           wr_edge[$];
    logic [W-1:0] wr_data[$];
    bit           wr_lr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_clear();
        edge_n   = 0;
        hist.delete();
        exp_q.delete();
        exp_ch_q.delete();
        cur_data = '0;
        cur_lr   = 1'b0;
        frames   = 0;
        wr_edge.delete();
        wr_data.delete();
        wr_lr.delete();
    endtask

    // One clock: apply reset level and data on the falling edge, then
    // check outputs just after the rising edge.
    task automatic do_edge(input bit r, input bit b);
        logic [W-1:0] w;
        bit           exp_wr;
        @(negedge clk);
        rst_i    = r;
        bus.sdat = b;
        @(posedge clk);
        #1;
        if (!r) begin
            model_clear();
            check("rst_sclk", 32'(bus.sclk), 32'd0);
            check("rst_wsel", 32'(bus.wsel), 32'd0);
            check("rst_data", 32'(bus.data), 32'd0);
            check("rst_lr", 32'(bus.lr_chnl), 32'd0);
            check("rst_write", 32'(bus.write), 32'd0);
`ifdef I2S_RX_FRAME_CNT_EN
            check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        end else begin
            edge_n++;
            hist.push_back(b);
            // Word complete when its LSB arrives: edges W+1, 2W+1, ...
            if (edge_n >= W + 1 && (edge_n - 1) % W == 0) begin
                for (int i = 0; i < W; i++) w[W-1-i] = hist[edge_n - W + i];
                exp_q.push_back(w);
                exp_ch_q.push_back(((edge_n - 1 - W) / W) % 2 == 1);
            end
            exp_wr = (edge_n >= W + 2) && ((edge_n - 2) % W == 0);
            check("write", 32'(bus.write), 32'(exp_wr));
            if (exp_wr) begin
                if (exp_q.size() == 0) begin
                    check("exp_queue_empty", 32'd0, 32'd1);
                end else begin
                    cur_data = exp_q.pop_front();
                    cur_lr   = exp_ch_q.pop_front();
                    if (cur_lr) frames++;
                end
            end
            if (bus.write) begin
                wr_edge.push_back(edge_n);
                wr_data.push_back(bus.data);
                wr_lr.push_back(bus.lr_chnl);
            end
            check("data", 32'(bus.data), 32'(cur_data));
            check("lr_chnl", 32'(bus.lr_chnl), 32'(cur_lr));
            check("wsel", 32'(bus.wsel), 32'((edge_n / W) % 2));
            check("sclk_run", 32'(bus.sclk), 32'd1);
`ifdef I2S_RX_FRAME_CNT_EN
            check("frame_cnt", 32'(frame_cnt), 32'(frames));
`endif
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) do_edge(1'b0, 1'($urandom_range(0, 1)));
    endtask

    // mode 0: random bits
    // mode 1: random delay bit, then A5C3 (left), 5A3C (right), then random
    // mode 2: words alternating 0000 / FFFF after the delay bit
    task automatic run(input int mode, input int n);
        int           nxt;
        int           k;
        logic [W-1:0] w;
        bit           b;
        for (int i = 0; i < n; i++) begin
            nxt = edge_n + 1;
            b   = 1'($urandom_range(0, 1));
            if (nxt >= 2 && mode != 0) begin
                k = (nxt - 2) / W;
                if (mode == 1) w = (k == 0) ? 16'hA5C3 : (k == 1) ? 16'h5A3C : W'($urandom);
                else           w = (k % 2 == 1) ? 16'hFFFF : 16'h0000;
                b = w[W-1-((nxt - 2) % W)];
            end
            do_edge(1'b1, b);
        end
    endtask

    initial begin
        bus.sdat = 1'b0;
        model_clear();

        // Reset state, then the two-word reference frame
        do_reset(3);
        run(1, 40);
        check("ref_write_count", 32'(wr_edge.size()), 32'd2);
        if (wr_edge.size() >= 2) begin
            check("ref_left_edge", 32'(wr_edge[0]), 32'd18);
            check("ref_left_data", 32'(wr_data[0]), 32'hA5C3);
            check("ref_left_lr", 32'(wr_lr[0]), 32'd0);
            check("ref_right_edge", 32'(wr_edge[1]), 32'd34);
            check("ref_right_data", 32'(wr_data[1]), 32'h5A3C);
            check("ref_right_lr", 32'(wr_lr[1]), 32'd1);
        end

        // Alternating all-zero / all-one words, 10 words
        do_reset(2);
        run(2, 1 + 10 * W + 1);
        check("alt_write_count", 32'(wr_edge.size()), 32'd10);
        for (int i = 0; i < wr_data.size(); i++) begin
            check("alt_word", 32'(wr_data[i]), (i % 2 == 1) ? 32'hFFFF : 32'h0000);
        end

        // Random traffic
        do_reset(2);
        run(0, 8 * W + 5);

        // Reset in the middle of a left word (8 bits in), then restart
        do_reset(2);
        run(0, 9);
        do_reset(3);
        run(0, 2 * W + 2);
        check("restart_write_count", 32'(wr_edge.size()), 32'd2);
        if (wr_edge.size() >= 1) begin
            check("restart_first_lr", 32'(wr_lr[0]), 32'd0);
            check("restart_first_edge", 32'(wr_edge[0]), 32'(W + 2));
        end

`ifdef I2S_RX_FRAME_CNT_EN
        // Five stereo frames
        do_reset(2);
        run(0, 1 + 10 * W + 1);
        check("frames_5", 32'(frame_cnt), 32'd5);
`endif

        // Long random run to finish
        do_reset(1);
        run(0, 20 * W);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
